// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
//   Rotates through NUM_OBSTACLES obstacle slots. Each obstacle is live for
//   ACTIVE_FRAMES frame ticks (or until obstacle_done), followed by
//   GAP_FRAMES blank ticks, after which the next slot is selected.
//
// Ports
//   pclk            pixel clock, all logic on rising edge
//   rst             asynchronous active-high reset
//   vsync_in        vertical sync; a registered rising edge is the frame tick
//   play_selected   level, game screen active
//   game_over       level, player lost (freezes into STOPPED)
//   menu_on         level, leaves STOPPED back to IDLE
//   obstacle_done   1-cycle pulse, ends the live obstacle early
//   obstacle_select registered obstacle mux select
//   obstacle_active registered, high while the selected obstacle is live
//   obstacle_start  registered 1-cycle pulse on each obstacle activation
//   round_count     registered count of completed rotations, saturating

module obstacle_scheduler #(
    parameter int NUM_OBSTACLES = 2,
    parameter int ACTIVE_FRAMES = 600,
    parameter int GAP_FRAMES    = 60
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       play_selected,
    input  logic       game_over,
    input  logic       menu_on,
    input  logic       obstacle_done,
    output logic [3:0] obstacle_select,
    output logic       obstacle_active,
    output logic       obstacle_start,
    output logic [7:0] round_count
);

    localparam logic [11:0] ACT_LAST = 12'(ACTIVE_FRAMES - 1);
    localparam logic [11:0] GAP_LAST = 12'(GAP_FRAMES - 1);
    localparam logic [3:0]  SEL_LAST = 4'(NUM_OBSTACLES - 1);

    typedef enum logic [2:0] {IDLE, ARM, ACTIVE, GAP, STOPPED} state_t;

    state_t      state, state_nx;
    logic        vsync_prev;
    logic        frame_tick;
    logic [11:0] frame_cnt, frame_cnt_nx;
    logic [3:0]  sel_nx;
    logic [7:0]  round_nx;
    logic        start_nx;

    // Frame tick is registered: it is high for the cycle following the
    // edge at which vsync_in was first sampled high.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            frame_tick <= vsync_in & ~vsync_prev;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            frame_cnt       <= '0;
            obstacle_select <= '0;
            round_count     <= '0;
            obstacle_active <= 1'b0;
            obstacle_start  <= 1'b0;
        end else begin
            state           <= state_nx;
            frame_cnt       <= frame_cnt_nx;
            obstacle_select <= sel_nx;
            round_count     <= round_nx;
            obstacle_active <= (state_nx == ACTIVE);
            obstacle_start  <= start_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        sel_nx       = obstacle_select;
        round_nx     = round_count;
        start_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (play_selected && !game_over)
                    state_nx = ARM;
            end

            ARM, ACTIVE, GAP: begin
                // Priority: game_over, then play drop, then done, then tick.
                if (game_over) begin
                    state_nx = STOPPED;
                end else if (!play_selected) begin
                    state_nx     = IDLE;
                    frame_cnt_nx = '0;
                    sel_nx       = '0;
                    round_nx     = '0;
                end else if (state == ARM) begin
                    if (frame_tick) begin
                        state_nx     = ACTIVE;
                        frame_cnt_nx = '0;
                        start_nx     = 1'b1;
                    end
                end else if (state == ACTIVE) begin
                    // done wins over a coincident final tick: one GAP entry.
                    if (obstacle_done) begin
                        state_nx     = GAP;
                        frame_cnt_nx = '0;
                    end else if (frame_tick) begin
                        if (frame_cnt == ACT_LAST) begin
                            state_nx     = GAP;
                            frame_cnt_nx = '0;
                        end else begin
                            frame_cnt_nx = frame_cnt + 12'd1;
                        end
                    end
                end else begin
                    if (frame_tick) begin
                        if (frame_cnt == GAP_LAST) begin
                            state_nx     = ACTIVE;
                            frame_cnt_nx = '0;
                            start_nx     = 1'b1;
                            if (obstacle_select == SEL_LAST) begin
                                sel_nx = '0;
                                if (round_count != 8'hFF)
                                    round_nx = round_count + 8'd1;
                            end else begin
                                sel_nx = obstacle_select + 4'd1;
                            end
                        end else begin
                            frame_cnt_nx = frame_cnt + 12'd1;
                        end
                    end
                end
            end

            STOPPED: begin
                if (menu_on) begin
                    state_nx     = IDLE;
                    frame_cnt_nx = '0;
                    sel_nx       = '0;
                    round_nx     = '0;
                end
            end

            default: begin
                state_nx     = IDLE;
                frame_cnt_nx = '0;
                sel_nx       = '0;
                round_nx     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

    localparam int AF = 3;
    localparam int GF = 2;

    logic       pclk = 1'b0;
    logic       rst, vsync_in, play_selected, game_over, menu_on, obstacle_done;
    logic [3:0] sel0, sel1;
    logic       act0, act1, st0, st1;
    logic [7:0] rc0, rc1;

    always #5 pclk = ~pclk;

    obstacle_scheduler #(.NUM_OBSTACLES(2), .ACTIVE_FRAMES(AF), .GAP_FRAMES(GF)) dut0 (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .play_selected(play_selected),
        .game_over(game_over), .menu_on(menu_on), .obstacle_done(obstacle_done),
        .obstacle_select(sel0), .obstacle_active(act0), .obstacle_start(st0),
        .round_count(rc0));

    obstacle_scheduler #(.NUM_OBSTACLES(1), .ACTIVE_FRAMES(AF), .GAP_FRAMES(GF)) dut1 (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .play_selected(play_selected),
        .game_over(game_over), .menu_on(menu_on), .obstacle_done(obstacle_done),
        .obstacle_select(sel1), .obstacle_active(act1), .obstacle_start(st1),
        .round_count(rc1));

    int checks = 0;
    int errors = 0;

    // Behavioural model: a game is either not running, halted, waiting for
    // its first frame, live or blank; frames_left counts down to the switch.
    int m_n[2];
    bit m_run[2], m_halt[2], m_wait[2], m_live[2], m_start[2];
    int m_left[2], m_sel[2], m_rounds[2];
    bit m_vprev, m_tick;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_halt[i] = 0; m_wait[i] = 0; m_live[i] = 0;
            m_start[i] = 0; m_left[i] = 0; m_sel[i] = 0; m_rounds[i] = 0;
        end
        m_vprev = 0;
        m_tick  = 0;
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            m_start[i] = 0;
            if (m_halt[i]) begin
                if (menu_on) begin
                    m_halt[i] = 0; m_sel[i] = 0; m_rounds[i] = 0;
                end
            end else if (!m_run[i]) begin
                if (play_selected && !game_over) begin
                    m_run[i] = 1; m_wait[i] = 1;
                end
            end else if (game_over) begin
                m_halt[i] = 1; m_run[i] = 0; m_live[i] = 0; m_wait[i] = 0;
            end else if (!play_selected) begin
                m_run[i] = 0; m_live[i] = 0; m_wait[i] = 0;
                m_sel[i] = 0; m_rounds[i] = 0;
            end else if (m_wait[i]) begin
                if (m_tick) begin
                    m_wait[i] = 0; m_live[i] = 1; m_left[i] = AF; m_start[i] = 1;
                end
            end else if (m_live[i]) begin
                if (obstacle_done) begin
                    m_live[i] = 0; m_left[i] = GF;
                end else if (m_tick) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_live[i] = 0; m_left[i] = GF;
                    end
                end
            end else if (m_tick) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_sel[i] = (m_sel[i] + 1) % m_n[i];
                    if (m_sel[i] == 0 && m_rounds[i] < 255) m_rounds[i]++;
                    m_live[i] = 1; m_left[i] = AF; m_start[i] = 1;
                end
            end
        end
        m_tick  = vsync_in & ~m_vprev;
        m_vprev = vsync_in;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("sel0", 32'(sel0), 32'(m_sel[0]));
        check("active0", 32'(act0), 32'(m_live[0]));
        check("start0", 32'(st0), 32'(m_start[0]));
        check("round0", 32'(rc0), 32'(m_rounds[0]));
        check("sel1", 32'(sel1), 32'(m_sel[1]));
        check("active1", 32'(act1), 32'(m_live[1]));
        check("start1", 32'(st1), 32'(m_start[1]));
        check("round1", 32'(rc1), 32'(m_rounds[1]));
    endtask

    task automatic step();
        @(posedge pclk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    // One frame: vsync high for one cycle, low for one cycle.
    task automatic frame();
        vsync_in = 1; step();
        vsync_in = 0; step();
    endtask

    typedef struct {
        bit play, go, menu, done, vs;
        int sel, act, st, rc;
    } vec_t;
    vec_t tbl[22];

    int vs_cnt, vs_len;
    bit found;

    initial begin
        m_n[0] = 2; m_n[1] = 1;
        model_reset();
        rst = 1; vsync_in = 0; play_selected = 0; game_over = 0;
        menu_on = 0; obstacle_done = 0;

        // play go menu done vs | sel act start round
        tbl[0]  = '{1,0,0,0,0, 0,0,0,0};
        tbl[1]  = '{1,0,0,0,1, 0,0,0,0};
        tbl[2]  = '{1,0,0,0,0, 0,1,1,0};
        tbl[3]  = '{1,0,0,0,1, 0,1,0,0};
        tbl[4]  = '{1,0,0,0,0, 0,1,0,0};
        tbl[5]  = '{1,0,0,0,1, 0,1,0,0};
        tbl[6]  = '{1,0,0,0,0, 0,1,0,0};
        tbl[7]  = '{1,0,0,0,1, 0,1,0,0};
        tbl[8]  = '{1,0,0,0,0, 0,0,0,0};
        tbl[9]  = '{1,0,0,0,1, 0,0,0,0};
        tbl[10] = '{1,0,0,0,0, 0,0,0,0};
        tbl[11] = '{1,0,0,0,1, 0,0,0,0};
        tbl[12] = '{1,0,0,0,0, 1,1,1,0};
        tbl[13] = '{1,0,0,0,1, 1,1,0,0};
        tbl[14] = '{1,0,0,1,0, 1,0,0,0};
        tbl[15] = '{1,0,0,0,1, 1,0,0,0};
        tbl[16] = '{1,0,0,0,0, 1,0,0,0};
        tbl[17] = '{1,0,0,1,1, 1,0,0,0};
        tbl[18] = '{1,0,0,0,0, 0,1,1,1};
        tbl[19] = '{1,1,0,0,1, 0,0,0,1};
        tbl[20] = '{0,0,0,0,0, 0,0,0,1};
        tbl[21] = '{0,0,1,0,0, 0,0,0,0};

        // Reset state
        step(); step();
        check("rst_sel", 32'(sel0), 0);
        check("rst_active", 32'(act0), 0);
        check("rst_start", 32'(st0), 0);
        check("rst_round", 32'(rc0), 0);
        rst = 0;

        // Table vectors
        for (int r = 0; r < 22; r++) begin
            play_selected = tbl[r].play; game_over = tbl[r].go; menu_on = tbl[r].menu;
            obstacle_done = tbl[r].done; vsync_in = tbl[r].vs;
            step();
            check($sformatf("tbl%0d_sel", r), 32'(sel0), 32'(tbl[r].sel));
            check($sformatf("tbl%0d_active", r), 32'(act0), 32'(tbl[r].act));
            check($sformatf("tbl%0d_start", r), 32'(st0), 32'(tbl[r].st));
            check($sformatf("tbl%0d_round", r), 32'(rc0), 32'(tbl[r].rc));
        end
        menu_on = 0; obstacle_done = 0;

        // game_over during GAP with select=1, then menu
        play_selected = 1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            frame();
            found = m_run[0] && !m_wait[0] && !m_live[0] && m_sel[0] == 1;
        end
        check("gap_sel1_reached", 32'(found), 1);
        game_over = 1; step();
        check("stop_sel", 32'(sel0), 1);
        check("stop_active", 32'(act0), 0);
        game_over = 0;
        for (int k = 0; k < 4; k++) begin
            frame();
            check("stop_no_start", 32'(st0), 0);
            check("stop_sel_frozen", 32'(sel0), 1);
        end
        menu_on = 1; step();
        check("menu_sel", 32'(sel0), 0);
        check("menu_round", 32'(rc0), 0);
        menu_on = 0;

        // game_over and play drop together -> STOPPED, not IDLE
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            frame();
            found = m_live[0];
        end
        check("live_reached", 32'(found), 1);
        game_over = 1; play_selected = 0; step();
        game_over = 0; play_selected = 1;
        for (int k = 0; k < 4; k++) begin
            frame();
            check("go_drop_stopped_active", 32'(act0), 0);
            check("go_drop_stopped_start", 32'(st0), 0);
        end
        menu_on = 1; step();
        menu_on = 0;

        // Async reset mid-ACTIVE
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            frame();
            found = m_live[0];
        end
        check("live_reached2", 32'(found), 1);
        #3 rst = 1;
        #1;
        check("async_sel", 32'(sel0), 0);
        check("async_active", 32'(act0), 0);
        check("async_start", 32'(st0), 0);
        check("async_round", 32'(rc0), 0);
        model_reset();
        step(); step();
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_no_start", 32'(st0), 0);
        end
        frame(); frame();

        // Randomized run against the model
        vs_cnt = 0; vs_len = 2;
        for (int c = 0; c < 4000; c++) begin
            if (++vs_cnt >= vs_len) begin
                vsync_in = ~vsync_in; vs_cnt = 0; vs_len = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 199) == 0) play_selected = ~play_selected;
            game_over     = ($urandom_range(0, 299) == 0);
            menu_on       = ($urandom_range(0, 19) == 0);
            obstacle_done = ($urandom_range(0, 39) == 0);
            if (!play_selected && $urandom_range(0, 9) == 0) play_selected = 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_OBSTACLES, default 2, meaning the number of obstacle slots to rotate through (range 1..16).
REQ-002 The module SHALL have parameter ACTIVE_FRAMES, default 600, meaning the frames each obstacle stays active (range 1..4095).
REQ-003 The module SHALL have parameter GAP_FRAMES, default 60, meaning the blank frames between obstacles (range 1..4095).
REQ-004 The module SHALL have port pclk, input, 1 bit: the single pixel clock; all logic runs on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port vsync_in, input, 1 bit: VGA vertical sync from the timing chain.
REQ-007 The module SHALL have port play_selected, input, 1 bit: level, game screen active.
REQ-008 The module SHALL have port game_over, input, 1 bit: level, player lost.
REQ-009 The module SHALL have port menu_on, input, 1 bit: level, return-to-menu request.
REQ-010 The module SHALL have port obstacle_done, input, 1 bit: 1-cycle pulse; the current obstacle ends early.
REQ-011 The module SHALL have port obstacle_select, output, 4 bits: obstacle mux select.
REQ-012 The module SHALL have port obstacle_active, output, 1 bit: high while the selected obstacle is live; downstream damage logic is gated by it.
REQ-013 The module SHALL have port obstacle_start, output, 1 bit: 1-cycle pulse when an obstacle becomes active.
REQ-014 The module SHALL have port round_count, output, 8 bits: count of completed full rotations.

Function
REQ-015 A frame tick SHALL be the cycle after vsync_in is sampled 0 and then 1 (rising edge, one register stage); only ticks advance frame counts.
REQ-016 The FSM SHALL have exactly the states IDLE, ARM, ACTIVE, GAP and STOPPED.
REQ-017 IDLE: when play_selected=1 and game_over=0, the FSM SHALL move to ARM; obstacle_select=0, obstacle_active=0.
REQ-018 ARM: on the next frame tick, the FSM SHALL enter ACTIVE, clear the frame counter, and assert obstacle_start for that one cycle with obstacle_active=1.
REQ-019 ACTIVE: the frame counter SHALL increment per tick; at a tick with count==ACTIVE_FRAMES-1, or on an obstacle_done pulse, the FSM SHALL enter GAP with a cleared counter and obstacle_active=0 from the following cycle.
REQ-020 GAP: at a tick with count==GAP_FRAMES-1, obstacle_select SHALL advance by one, wrapping from NUM_OBSTACLES-1 to 0, and the FSM SHALL enter ACTIVE with an obstacle_start pulse.
REQ-021 On each wrap to 0, round_count SHALL increment, saturating at 255.
REQ-022 obstacle_done SHALL be ignored outside ACTIVE; obstacle_done coincident with the final tick SHALL cause a single transition to GAP.
REQ-023 game_over=1 in ARM, ACTIVE or GAP SHALL force STOPPED on the next edge, with obstacle_select and round_count frozen and obstacle_active=0.
REQ-024 STOPPED: menu_on=1 SHALL return the FSM to IDLE, clearing obstacle_select, round_count and counters.
REQ-025 play_selected=0 in ARM, ACTIVE or GAP (without game_over) SHALL return the FSM to IDLE with the same clearing.
REQ-026 Priority each cycle SHALL be: game_over > play_selected drop > obstacle_done > frame tick.
REQ-027 With NUM_OBSTACLES=1, obstacle_select SHALL stay 0 and round_count SHALL increment every GAP exit.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 SHALL immediately force IDLE with obstacle_select=0, obstacle_active=0, obstacle_start=0, round_count=0, counters=0, and the vsync history register=0.
REQ-030 rst asserted mid-ACTIVE SHALL abort the obstacle with no obstacle_start pulse on release; operation resumes via IDLE->ARM.

Verification (NUM_OBSTACLES=2, ACTIVE_FRAMES=3, GAP_FRAMES=2)
REQ-031 Raise play_selected, then apply vsync pulses -> at the first tick, obstacle_start is high for 1 cycle, select=0 and active=1; after 3 ticks active=0; after 2 more ticks select=1 with a start pulse.
REQ-032 Run 10 ACTIVE+GAP periods -> select sequence 0,1,0,1,...; round_count increments at each 1->0 wrap.
REQ-033 Pulse obstacle_done during the first ACTIVE frame -> GAP entered next cycle; select advances after 2 ticks.
REQ-034 Assert game_over during GAP with select=1 -> STOPPED, select stays 1, active=0, no further starts; then menu_on=1 -> IDLE, select=0, round_count=0.
REQ-035 Assert game_over and drop play_selected in the same cycle -> STOPPED (not IDLE).
REQ-036 Assert rst asynchronously mid-ACTIVE -> outputs read 0 before the next pclk edge; no start pulse after release until ARM plus a tick.
